// File: rtl/ram_arb.sv
// ram_arb: shares one single-port RAM between the debug loader (DBG), the CPU
// data port (DP) and the CPU instruction-fetch port (IP).
//   - DBG has absolute priority; IP and DP alternate via a round-robin pointer.
//   - One access per cycle; gnt is a combinational pulse in the cycle the
//     access is driven onto the RAM port.
//   - Reads return on <x>_rvld_o / <x>_rdata_o exactly RD_LAT cycles after gnt,
//     in issue order; <x>_rdata_o holds until that requester's next return.
// Ports:
//   clk_i, rst_n_i                 clock, async active-low reset
//   dbg_* / dp_*                   req, byte addr, wbe (0 = read), wdata, gnt, rvld, rdata
//   ip_*                           req, byte addr, gnt, rvld, rdata (read only)
//   ram_addr_o/wbe_o/wdata_o/rd_o  RAM command port (word-aligned address)
//   ram_rdata_i                    RAM read data, valid RD_LAT cycles after ram_rd_o
module ram_arb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,

    input  logic            dbg_req_i,
    input  logic [XLEN-1:0] dbg_addr_i,
    input  logic [3:0]      dbg_wbe_i,
    input  logic [XLEN-1:0] dbg_wdata_i,
    output logic            dbg_gnt_o,
    output logic            dbg_rvld_o,
    output logic [XLEN-1:0] dbg_rdata_o,

    input  logic            dp_req_i,
    input  logic [XLEN-1:0] dp_addr_i,
    input  logic [3:0]      dp_wbe_i,
    input  logic [XLEN-1:0] dp_wdata_i,
    output logic            dp_gnt_o,
    output logic            dp_rvld_o,
    output logic [XLEN-1:0] dp_rdata_o,

    input  logic            ip_req_i,
    input  logic [XLEN-1:0] ip_addr_i,
    output logic            ip_gnt_o,
    output logic            ip_rvld_o,
    output logic [XLEN-1:0] ip_rdata_o,

    output logic [XLEN-1:0] ram_addr_o,
    output logic [3:0]      ram_wbe_o,
    output logic [XLEN-1:0] ram_wdata_o,
    output logic            ram_rd_o,
    input  logic [XLEN-1:0] ram_rdata_i
);

    localparam int unsigned WBE_W = 4;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_DBG  = 2'd1,
        SRC_DP   = 2'd2,
        SRC_IP   = 2'd3
    } src_e;

    src_e              sel;
    logic              rr_ip;        // 1: IP wins the next IP/DP tie
    logic [XLEN-1:0]   sel_addr;
    logic [XLEN-1:0]   sel_wdata;
    logic [WBE_W-1:0]  sel_wbe;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [RD_LAT-1:0] tag_vld;
    src_e              tag_src [RD_LAT];
    logic              ret_vld;
    src_e              ret_src;
    logic [XLEN-1:0]   dbg_rdata_q;
    logic [XLEN-1:0]   dp_rdata_q;
    logic [XLEN-1:0]   ip_rdata_q;

    // Arbitration; nothing is granted while reset is asserted.
    always_comb begin
        sel = SRC_NONE;
        if (rst_n_i) begin
            if (dbg_req_i) begin
                sel = SRC_DBG;
            end else if (ip_req_i && dp_req_i) begin
                sel = rr_ip ? SRC_IP : SRC_DP;
            end else if (ip_req_i) begin
                sel = SRC_IP;
            end else if (dp_req_i) begin
                sel = SRC_DP;
            end
        end
    end

    // Command mux from the granted requester.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wbe   = '0;
        case (sel)
            SRC_DBG: begin
                sel_addr  = dbg_addr_i;
                sel_wdata = dbg_wdata_i;
                sel_wbe   = dbg_wbe_i;
            end
            SRC_DP: begin
                sel_addr  = dp_addr_i;
                sel_wdata = dp_wdata_i;
                sel_wbe   = dp_wbe_i;
            end
            SRC_IP: begin
                sel_addr  = ip_addr_i;
            end
            default: ;
        endcase
    end

    // RAM port and grant pulses; address/data hold their last value when idle.
    always_comb begin
        dbg_gnt_o   = (sel == SRC_DBG);
        dp_gnt_o    = (sel == SRC_DP);
        ip_gnt_o    = (sel == SRC_IP);
        ram_wbe_o   = sel_wbe;
        ram_rd_o    = (sel != SRC_NONE) && (sel_wbe == '0);
        ram_addr_o  = addr_q;
        ram_wdata_o = wdata_q;
        if (sel != SRC_NONE) begin
            ram_addr_o  = sel_addr & ~XLEN'(3);
            ram_wdata_o = sel_wdata;
        end
    end

    // Round-robin pointer and held RAM address/data.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_ip   <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (sel == SRC_IP) rr_ip <= 1'b0;
            if (sel == SRC_DP) rr_ip <= 1'b1;
            addr_q  <= ram_addr_o;
            wdata_q <= ram_wdata_o;
        end
    end

    // Read tag pipeline: one stage per cycle of RAM latency.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tag_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_src[i] <= SRC_NONE;
        end else begin
            tag_vld[0] <= ram_rd_o;
            tag_src[0] <= sel;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_src[i] <= tag_src[i-1];
            end
        end
    end

    assign ret_vld = tag_vld[RD_LAT-1];
    assign ret_src = tag_src[RD_LAT-1];

    // Return steering: data is forwarded in the return cycle, then held.
    always_comb begin
        dbg_rvld_o  = ret_vld && (ret_src == SRC_DBG);
        dp_rvld_o   = ret_vld && (ret_src == SRC_DP);
        ip_rvld_o   = ret_vld && (ret_src == SRC_IP);
        dbg_rdata_o = dbg_rvld_o ? ram_rdata_i : dbg_rdata_q;
        dp_rdata_o  = dp_rvld_o  ? ram_rdata_i : dp_rdata_q;
        ip_rdata_o  = ip_rvld_o  ? ram_rdata_i : ip_rdata_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dbg_rdata_q <= '0;
            dp_rdata_q  <= '0;
            ip_rdata_q  <= '0;
        end else begin
            if (dbg_rvld_o) dbg_rdata_q <= ram_rdata_i;
            if (dp_rvld_o)  dp_rdata_q  <= ram_rdata_i;
            if (ip_rvld_o)  ip_rdata_q  <= ram_rdata_i;
        end
    end

endmodule

// File: tb/tb_ram_arb.sv
// Randomized scoreboard bench for ram_arb with a behavioural RAM and a
// priority/round-robin reference model.
module tb_ram_arb;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RD_LAT = 2;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            dbg_req_i, dp_req_i, ip_req_i;
    logic [XLEN-1:0] dbg_addr_i, dp_addr_i, ip_addr_i;
    logic [3:0]      dbg_wbe_i, dp_wbe_i;
    logic [XLEN-1:0] dbg_wdata_i, dp_wdata_i;
    logic            dbg_gnt_o, dp_gnt_o, ip_gnt_o;
    logic            dbg_rvld_o, dp_rvld_o, ip_rvld_o;
    logic [XLEN-1:0] dbg_rdata_o, dp_rdata_o, ip_rdata_o;
    logic [XLEN-1:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
    logic [3:0]      ram_wbe_o;
    logic            ram_rd_o;

    ram_arb #(.XLEN(XLEN), .RD_LAT(RD_LAT)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_wbe_i(dbg_wbe_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o), .dbg_rvld_o(dbg_rvld_o),
        .dbg_rdata_o(dbg_rdata_o),
        .dp_req_i(dp_req_i), .dp_addr_i(dp_addr_i), .dp_wbe_i(dp_wbe_i),
        .dp_wdata_i(dp_wdata_i), .dp_gnt_o(dp_gnt_o), .dp_rvld_o(dp_rvld_o),
        .dp_rdata_o(dp_rdata_o),
        .ip_req_i(ip_req_i), .ip_addr_i(ip_addr_i), .ip_gnt_o(ip_gnt_o),
        .ip_rvld_o(ip_rvld_o), .ip_rdata_o(ip_rdata_o),
        .ram_addr_o(ram_addr_o), .ram_wbe_o(ram_wbe_o), .ram_wdata_o(ram_wdata_o),
        .ram_rd_o(ram_rd_o), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Contents of a never-written word, derived from its word address.
    function automatic logic [31:0] mem_init(input logic [31:0] wa);
        return {wa[15:0] ^ 16'hA5A5, ~wa[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] wbe);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (wbe[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // ---------------- behavioural RAM driven by the DUT's RAM port ----------------
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] rd_pipe [RD_LAT];

    initial for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;

    always @(posedge clk_i) begin
        logic [31:0] wa;
        logic [31:0] cur;
        wa  = ram_addr_o >> 2;
        cur = ram_mem.exists(wa) ? ram_mem[wa] : mem_init(wa);
        if (ram_wbe_o != 4'b0) begin
            cur = merge(cur, ram_wdata_o, ram_wbe_o);
            ram_mem[wa] = cur;
        end
        for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= ram_rd_o ? cur : $urandom;
    end

    assign ram_rdata_i = rd_pipe[RD_LAT-1];

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int          id;     // 0 dbg, 1 dp, 2 ip
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic        rr_ip_m = 1'b1;
    logic [31:0] last_addr_m = '0;
    logic [31:0] last_wdata_m = '0;
    logic [31:0] hold_m [3] = '{default: '0};
    logic        g_dbg = 1'b0, g_dp = 1'b0, g_ip = 1'b0;

    // Grant / RAM-port checker; issues expected read returns into exp_q.
    always @(negedge clk_i) begin
        logic [2:0]  eg;
        logic [31:0] a, wd, wa, cur;
        logic [3:0]  wbe;
        int          id;
        g_dbg = dbg_gnt_o;
        g_dp  = dp_gnt_o;
        g_ip  = ip_gnt_o;
        if (!rst_n_i) begin
            chk("rst_gnt", {dbg_gnt_o, dp_gnt_o, ip_gnt_o}, 0);
            chk("rst_rvld", {dbg_rvld_o, dp_rvld_o, ip_rvld_o}, 0);
            chk("rst_rdata", {32'(dbg_rdata_o | dp_rdata_o), ip_rdata_o}, 0);
            chk("rst_ram", {ram_addr_o, ram_wbe_o, ram_rd_o}, 0);
            chk("rst_wdata", ram_wdata_o, 0);
            exp_q.delete();
            rr_ip_m      = 1'b1;
            last_addr_m  = '0;
            last_wdata_m = '0;
            hold_m       = '{default: '0};
        end else begin
            eg = 3'b000; a = '0; wd = '0; wbe = '0; id = -1;
            if (dbg_req_i)                 id = 0;
            else if (dp_req_i && ip_req_i) id = rr_ip_m ? 2 : 1;
            else if (ip_req_i)             id = 2;
            else if (dp_req_i)             id = 1;
            case (id)
                0: begin eg = 3'b100; a = dbg_addr_i; wd = dbg_wdata_i; wbe = dbg_wbe_i; end
                1: begin eg = 3'b010; a = dp_addr_i;  wd = dp_wdata_i;  wbe = dp_wbe_i;  end
                2: begin eg = 3'b001; a = ip_addr_i; end
                default: ;
            endcase
            chk("gnt", {dbg_gnt_o, dp_gnt_o, ip_gnt_o}, eg);
            if (id >= 0) begin
                last_addr_m  = {a[31:2], 2'b00};
                last_wdata_m = wd;
            end
            chk("ram_rd", ram_rd_o, (id >= 0) && (wbe == 4'b0));
            chk("ram_wbe", ram_wbe_o, wbe);
            chk("ram_addr", ram_addr_o, last_addr_m);
            chk("ram_wdata", ram_wdata_o, last_wdata_m);
            if (id >= 0) begin
                wa  = a >> 2;
                cur = ref_mem.exists(wa) ? ref_mem[wa] : mem_init(wa);
                if (wbe != 4'b0) ref_mem[wa] = merge(cur, wd, wbe);
                else exp_q.push_back('{id: id, data: cur, due: cyc + RD_LAT});
                if (id == 2) rr_ip_m = 1'b0;
                if (id == 1) rr_ip_m = 1'b1;
            end
        end
    end

    // Return monitor: pops the scoreboard whenever any rvld is seen.
    always @(negedge clk_i) begin
        logic [2:0] rv;
        exp_t       e;
        logic [31:0] got;
        if (rst_n_i) begin
            rv = {dbg_rvld_o, dp_rvld_o, ip_rvld_o};
            if (rv != 3'b000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rvld", rv, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rvld_port", rv, 3'b100 >> e.id);
                    chk("rvld_cycle", 64'(cyc), 64'(e.due));
                    got = (e.id == 0) ? dbg_rdata_o : (e.id == 1) ? dp_rdata_o : ip_rdata_o;
                    chk("rdata", got, e.data);
                    hold_m[e.id] = e.data;
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                chk("missing_rvld", 0, 3'b100 >> e.id);
            end
            chk("rdata_hold", {dbg_rdata_o, dp_rdata_o, ip_rdata_o},
                {hold_m[0], hold_m[1], hold_m[2]});
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(0, 63));
    endfunction

    function automatic logic [3:0] rnd_wbe();
        return ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
    endfunction

    // One cycle of protocol-respecting requesters: hold until granted.
    task automatic step(input int pd, input int pp, input int pi_);
        @(posedge clk_i); #1;
        if (!dbg_req_i || g_dbg) begin
            dbg_req_i = ($urandom_range(0, 99) < pd);
            dbg_addr_i = rnd_addr(); dbg_wbe_i = rnd_wbe(); dbg_wdata_i = $urandom;
        end
        if (!dp_req_i || g_dp) begin
            dp_req_i = ($urandom_range(0, 99) < pp);
            dp_addr_i = rnd_addr(); dp_wbe_i = rnd_wbe(); dp_wdata_i = $urandom;
        end
        if (!ip_req_i || g_ip) begin
            ip_req_i = ($urandom_range(0, 99) < pi_);
            ip_addr_i = rnd_addr();
        end
    endtask

    task automatic pulse_reset(input int n);
        @(posedge clk_i); #1;
        rst_n_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
    endtask

    task automatic reset_after_ip_grant();
        int k;
        k = 0;
        while (!g_ip && k < 50) begin
            step(20, 50, 90);
            k++;
        end
        if (!g_ip) chk("ip_grant_timeout", 0, 1);
        pulse_reset(2);
    endtask

    initial begin
        rst_n_i = 1'b0;
        dbg_req_i = 1'b1; dbg_addr_i = 32'h8; dbg_wbe_i = 4'b0; dbg_wdata_i = '0;
        dp_req_i  = 1'b1; dp_addr_i  = 32'h4; dp_wbe_i  = 4'b0; dp_wdata_i  = '0;
        ip_req_i  = 1'b1; ip_addr_i  = 32'h0;
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        dbg_req_i = 1'b0;

        // IP and DP saturating, DBG idle: strict alternation.
        repeat (12) step(0, 100, 100);
        // DBG continuously requesting starves IP/DP.
        repeat (12) step(100, 60, 100);
        repeat (8) step(0, 0, 0);

        // Directed: unaligned DBG write against a DP read, then read-back.
        @(posedge clk_i); #1;
        dbg_req_i = 1'b1; dbg_addr_i = 32'h0000_0103; dbg_wbe_i = 4'b0010;
        dbg_wdata_i = 32'h0000_AB00;
        dp_req_i = 1'b1; dp_addr_i = 32'h0000_0040; dp_wbe_i = 4'b0;
        repeat (4) step(0, 0, 0);
        @(posedge clk_i); #1;
        dbg_req_i = 1'b1; dbg_addr_i = 32'h10;  dbg_wbe_i = 4'b0;
        dp_req_i  = 1'b1; dp_addr_i  = 32'h14;  dp_wbe_i  = 4'b0;
        ip_req_i  = 1'b1; ip_addr_i  = 32'h102;
        repeat (8) step(0, 0, 0);

        // Mixed random traffic with resets landing on in-flight reads.
        repeat (60) step(30, 60, 60);
        reset_after_ip_grant();
        repeat (80) step(25, 70, 70);
        reset_after_ip_grant();
        repeat (150) step(15, 50, 50);

        repeat (RD_LAT + 6) step(0, 0, 0);
        chk("drain_empty", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
